ospfb_sched: RTL
================

// Module: ospfb_sched
// PURPOSE
//  Frame scheduler for the oversampled PFB (OSPFB) front end; sits between the input AXIS stream and the polyphase FIR.
//  Per output frame: accepts DEC_FAC new samples, then FFT_LEN-DEC_FAC loopback cycles.
//  Issues FIR step enables, the input/loopback select and the AXIS ready.
//  Tracks the phase-rotation offset needed ahead of the FFT, and flags input starvation.
// PARAMETERS
//  FFT_LEN  64  polyphase branches / samples per output frame; power of 2, >=4
//  DEC_FAC  48  new input samples per frame; 1 <= DEC_FAC < FFT_LEN
//  CNT_WID  16  width of frame counter
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  asynchronous, active-high reset
//  en           in   1                  run request; sampled only at frame boundaries
//  s_tvalid     in   1                  input AXIS sample valid
//  s_tready     out  1                  input AXIS ready (combinational)
//  dn_ready     in   1                  downstream (FFT) can accept a step
//  fir_en       out  1                  advance FIR/delay lines this cycle (combinational)
//  din_sel      out  1                  1 = FIR takes s_tdata, 0 = takes loopbuf
//  sample_idx   out  $clog2(FFT_LEN)    position within current frame
//  frame_start  out  1                  fir_en & sample_idx==0
//  frame_last   out  1                  fir_en & sample_idx==FFT_LEN-1
//  shift        out  $clog2(FFT_LEN)    phase-rotation offset for the current frame
//  frame_cnt    out  CNT_WID            completed frames, wraps
//  starve       out  1                  sticky: input needed but s_tvalid low while dn_ready
//  busy         out  1                  state==RUN
// BEHAVIOUR
//  Reset values: state=IDLE, sample_idx=0, shift=0, frame_cnt=0, starve=0.
//  All combinational outputs evaluate low in IDLE.
//  FSM:
//   IDLE -> RUN when en=1; transition takes 1 cycle; first step is possible in the first RUN cycle.
//   RUN: step = dn_ready & (din_sel ? s_tvalid : 1).
//   At the step with sample_idx==FFT_LEN-1: sample_idx->0; stay in RUN if en=1, else go to IDLE.
//   Deasserting en mid-frame does not stop the frame; the frame always completes.
//  Per-cycle outputs in RUN:
//   din_sel = (sample_idx < DEC_FAC)
//   s_tready = din_sel & dn_ready
//   fir_en = step
//   A handshake (s_tvalid & s_tready) occurs exactly when fir_en & din_sel.
//  Counters:
//   sample_idx increments only on fir_en.
//   No stall: a frame takes exactly FFT_LEN cycles with s_tready high for DEC_FAC of them.
//   Stall: holds all state; no output changes except the combinational ones.
//  Shift and frame count, updated on the frame_last step:
//   shift <= (shift + DEC_FAC) mod FFT_LEN, using natural wrap of the $clog2 width.
//   frame_cnt <= frame_cnt + 1, wrapping at 2^CNT_WID.
//   shift is constant for the whole frame.
//  starve: set when RUN & din_sel & dn_ready & !s_tvalid; cleared only by rst.
//  Simultaneous events:
//   dn_ready low has priority; s_tready stays low regardless of s_tvalid.
//   en low at frame_last with dn_ready low: the step has not occurred, so the frame is not complete.
//  Reset mid-frame: immediate return to IDLE and all reset values; the partial frame is discarded.
//  Elaboration: $error if DEC_FAC >= FFT_LEN or FFT_LEN is not a power of 2.
// TESTING  (FFT_LEN=64, DEC_FAC=48)
//  1. rst pulse mid-operation -> all outputs at reset values asynchronously, before the next clk edge.
//  2. en=1, s_tvalid=1, dn_ready=1 for 4 frames
//     -> s_tready high for 48 cycles then low for 16, per frame;
//     -> frame_start every 64 cycles;
//     -> shift per frame = 0,48,32,16; frame_cnt=4 at end.
//  3. s_tvalid low for cycles 10-14 of frame 0, dn_ready=1
//     -> fir_en low for those 5 cycles; starve=1;
//     -> frame_last occurs 5 cycles late; sample_idx frozen at 10.
//  4. dn_ready low for 3 cycles at sample_idx 50 (loopback region)
//     -> fir_en=0 and s_tready=0 for those cycles; starve stays 0; frame length 67 cycles.
//  5. en dropped at sample_idx 20
//     -> frame completes through idx 63; busy falls the cycle after frame_last;
//     -> no s_tready in IDLE; re-assert en -> next frame uses shift=48.
//  6. Run 2^CNT_WID+1 frames with CNT_WID=4 -> frame_cnt wraps to 1; shift sequence period 4 maintained.

Source files
------------

// File: rtl/ospfb_sched.sv
// Frame scheduler for the oversampled PFB front end: sequences DEC_FAC new samples
// plus FFT_LEN-DEC_FAC loopback steps per frame and tracks the FFT phase rotation.
module ospfb_sched #(
    parameter int FFT_LEN = 64,
    parameter int DEC_FAC = 48,
    parameter int CNT_WID = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       dn_ready,
    output logic                       fir_en,
    output logic                       din_sel,
    output logic [$clog2(FFT_LEN)-1:0] sample_idx,
    output logic                       frame_start,
    output logic                       frame_last,
    output logic [$clog2(FFT_LEN)-1:0] shift,
    output logic [CNT_WID-1:0]         frame_cnt,
    output logic                       starve,
    output logic                       busy
);

    localparam int IW = $clog2(FFT_LEN);
    localparam logic [IW-1:0] DEC_IDX  = IW'(DEC_FAC);
    localparam logic [IW-1:0] LAST_IDX = IW'(FFT_LEN - 1);

    if (DEC_FAC < 1 || DEC_FAC >= FFT_LEN || FFT_LEN < 4 ||
        (FFT_LEN & (FFT_LEN - 1)) != 0) begin : g_bad_params
        $error("ospfb_sched: need power-of-2 FFT_LEN >= 4 and 1 <= DEC_FAC < FFT_LEN");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;
    logic   starve_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // en is only honoured at frame boundaries, so a dropped en still finishes the frame.
    always_comb begin
        next_state = state;
        din_sel    = 1'b0;
        s_tready   = 1'b0;
        fir_en     = 1'b0;
        starve_hit = 1'b0;
        if (state == RUN) begin
            din_sel    = (sample_idx < DEC_IDX);
            s_tready   = din_sel & dn_ready;
            fir_en     = dn_ready & (din_sel ? s_tvalid : 1'b1);
            starve_hit = din_sel & dn_ready & ~s_tvalid;
            if (fir_en && sample_idx == LAST_IDX && !en) begin
                next_state = IDLE;
            end
        end else if (en) begin
            next_state = RUN;
        end
    end

    assign busy        = (state == RUN);
    assign frame_start = fir_en & (sample_idx == '0);
    assign frame_last  = fir_en & (sample_idx == LAST_IDX);

    // Index wraps naturally at FFT_LEN; shift and frame count advance only on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_idx <= '0;
            shift      <= '0;
            frame_cnt  <= '0;
            starve     <= 1'b0;
        end else begin
            if (fir_en) begin
                sample_idx <= sample_idx + 1'b1;
            end
            if (frame_last) begin
                shift     <= shift + DEC_IDX;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (starve_hit) begin
                starve <= 1'b1;
            end
        end
    end

endmodule
